// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main controller.
// Moore FSM driving a shared-ALU, single-memory datapath.
module multicycle_control_unit #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit EXT_ISA     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       BranchNe,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ImmZext,
    output logic [2:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        IMMEX  = 4'd9,
        IMMWB  = 4'd10,
        BRANCH = 4'd11,
        JUMP   = 4'd12,
        TRAP   = 4'd13
    } state_t;

    state_t state_q;
    state_t state_d;

    logic rdy;
    logic is_rtype;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_addi;
    logic is_andi;
    logic is_ori;
    logic is_slti;
    logic is_j;

    // With wait states disabled, memory always completes in one cycle.
    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    // Extended opcodes only count when the extended ISA is built in,
    // so without it they fall through to the trap.
    assign is_rtype = (opcode == 6'b000000);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_beq   = (opcode == 6'b000100);
    assign is_bne   = EXT_ISA && (opcode == 6'b000101);
    assign is_addi  = (opcode == 6'b001000);
    assign is_andi  = EXT_ISA && (opcode == 6'b001100);
    assign is_ori   = EXT_ISA && (opcode == 6'b001101);
    assign is_slti  = EXT_ISA && (opcode == 6'b001010);
    assign is_j     = (opcode == 6'b000010);

    assign state = state_q;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d    = state_q;
        IorD       = 1'b0;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        BranchNe   = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ImmZext    = 1'b0;
        ALUOp      = 3'b000;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = rdy;
                PCWrite = rdy;
                if (rdy) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                unique case (1'b1)
                    is_rtype:                  state_d = EXEC;
                    is_lw, is_sw:              state_d = MEMADR;
                    is_beq, is_bne:            state_d = BRANCH;
                    is_addi, is_andi,
                    is_ori, is_slti:           state_d = IMMEX;
                    is_j:                      state_d = JUMP;
                    default:                   state_d = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = is_sw ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD    = 1'b1;
                mem_req = 1'b1;
                if (rdy) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                IorD     = 1'b1;
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                if (rdy) begin
                    state_d = FETCH;
                end
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                unique case (1'b1)
                    is_andi: begin
                        ALUOp   = 3'b011;
                        ImmZext = 1'b1;
                    end
                    is_ori: begin
                        ALUOp   = 3'b100;
                        ImmZext = 1'b1;
                    end
                    is_slti: ALUOp = 3'b101;
                    default: ALUOp = 3'b000;
                endcase
                state_d = IMMWB;
            end
            IMMWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b001;
                PCSrc    = 2'b01;
                Branch   = is_beq;
                BranchNe = is_bne;
                state_d  = FETCH;
            end
            JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
                state_d = FETCH;
            end
            TRAP: begin
                illegal_op = 1'b1;
                state_d    = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// Two instances: full-featured, and no-ext-ISA / no-wait.
module tb_multicycle_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_ready_b;

    logic       IorD, mem_req, MemWrite, IRWrite, PCWrite;
    logic       Branch, BranchNe, ALUSrcA, ImmZext;
    logic       RegDst, MemtoReg, RegWrite, illegal_op;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUOp;
    logic [3:0] state;

    logic       IorD_b, mem_req_b, MemWrite_b, IRWrite_b, PCWrite_b;
    logic       Branch_b, BranchNe_b, ALUSrcA_b, ImmZext_b;
    logic       RegDst_b, MemtoReg_b, RegWrite_b, illegal_op_b;
    logic [1:0] PCSrc_b, ALUSrcB_b;
    logic [2:0] ALUOp_b;
    logic [3:0] state_b;

    int compared;
    int mismatched;

    multicycle_control_unit #(.MEM_WAIT_EN(1'b1), .EXT_ISA(1'b1)) u_a (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .mem_req(mem_req), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
        .BranchNe(BranchNe), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmZext(ImmZext), .ALUOp(ALUOp),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .illegal_op(illegal_op), .state(state)
    );

    multicycle_control_unit #(.MEM_WAIT_EN(1'b0), .EXT_ISA(1'b0)) u_b (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready_b),
        .IorD(IorD_b), .mem_req(mem_req_b), .MemWrite(MemWrite_b),
        .IRWrite(IRWrite_b), .PCWrite(PCWrite_b), .Branch(Branch_b),
        .BranchNe(BranchNe_b), .PCSrc(PCSrc_b), .ALUSrcA(ALUSrcA_b),
        .ALUSrcB(ALUSrcB_b), .ImmZext(ImmZext_b), .ALUOp(ALUOp_b),
        .RegDst(RegDst_b), .MemtoReg(MemtoReg_b), .RegWrite(RegWrite_b),
        .illegal_op(illegal_op_b), .state(state_b)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] outs_a();
        return {IorD, mem_req, MemWrite, IRWrite, PCWrite, Branch, BranchNe,
                PCSrc, ALUSrcA, ALUSrcB, ImmZext, ALUOp,
                RegDst, MemtoReg, RegWrite, illegal_op};
    endfunction

    function automatic logic [20:0] outs_b();
        return {IorD_b, mem_req_b, MemWrite_b, IRWrite_b, PCWrite_b,
                Branch_b, BranchNe_b, PCSrc_b, ALUSrcA_b, ALUSrcB_b,
                ImmZext_b, ALUOp_b, RegDst_b, MemtoReg_b, RegWrite_b,
                illegal_op_b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] lw_exp_st [10];
    logic       lw_mr     [10];
    int         pcw_cnt;
    int         irw_cnt;
    int         wb_ok;
    int         mw_cnt;
    int         rw_cnt;
    int         iord_ok;

    initial begin
        compared    = 0;
        mismatched  = 0;
        reset       = 1'b1;
        opcode      = 6'b000000;
        mem_ready   = 1'b1;
        mem_ready_b = 1'b0;

        // Reset held with mem_ready high: reset wins, everything zero.
        repeat (2) step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'(outs_a()), 32'd0);
        chk("rst_state_b", 32'(state_b), 32'd0);

        // Release: first edge enters FETCH.
        reset = 1'b0;
        step();
        chk("rel_fetch", 32'(state), 32'd1);
        chk("fetch_irw", 32'(IRWrite), 32'd1);
        chk("fetch_pcw", 32'(PCWrite), 32'd1);

        // R-type: 1,2,7,8,1.
        step();
        chk("r_dec", 32'(state), 32'd2);
        chk("r_dec_srcb", 32'(ALUSrcB), 32'd3);
        step();
        chk("r_exec", 32'(state), 32'd7);
        chk("r_exec_aluop", 32'(ALUOp), 32'd2);
        chk("r_exec_rw", 32'(RegWrite), 32'd0);
        step();
        chk("r_wb", 32'(state), 32'd8);
        chk("r_wb_rw", 32'(RegWrite), 32'd1);
        chk("r_wb_rd", 32'(RegDst), 32'd1);
        step();
        chk("r_done", 32'(state), 32'd1);

        // LW, 2 waits in FETCH and 3 in MEMRD: 10 cycles.
        lw_exp_st = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3,
                      4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
        lw_mr     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                      1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode  = 6'b100011;
        pcw_cnt = 0;
        irw_cnt = 0;
        wb_ok   = 0;
        for (int i = 0; i < 10; i++) begin
            mem_ready = lw_mr[i];
            #1;
            chk($sformatf("lw_st%0d", i), 32'(state), 32'(lw_exp_st[i]));
            if (PCWrite) pcw_cnt++;
            if (IRWrite) irw_cnt++;
            if (state == 4'd5 && MemtoReg && RegWrite) wb_ok++;
            step();
        end
        chk("lw_done", 32'(state), 32'd1);
        chk("lw_pcw_cnt", 32'(pcw_cnt), 32'd1);
        chk("lw_irw_cnt", 32'(irw_cnt), 32'd1);
        chk("lw_wb", 32'(wb_ok), 32'd1);

        // SW, ready immediately: 4 cycles, one MemWrite cycle.
        opcode    = 6'b101011;
        mem_ready = 1'b1;
        mw_cnt    = 0;
        rw_cnt    = 0;
        iord_ok   = 0;
        for (int i = 0; i < 4; i++) begin
            if (MemWrite) mw_cnt++;
            if (MemWrite && IorD) iord_ok++;
            if (RegWrite) rw_cnt++;
            step();
        end
        chk("sw_done", 32'(state), 32'd1);
        chk("sw_mw_cnt", 32'(mw_cnt), 32'd1);
        chk("sw_iord", 32'(iord_ok), 32'd1);
        chk("sw_rw_cnt", 32'(rw_cnt), 32'd0);

        // BNE on the extended-ISA instance.
        opcode = 6'b000101;
        step();
        step();
        chk("bne_state", 32'(state), 32'd11);
        chk("bne_bne", 32'(BranchNe), 32'd1);
        chk("bne_beq", 32'(Branch), 32'd0);
        chk("bne_aluop", 32'(ALUOp), 32'd1);
        chk("bne_pcsrc", 32'(PCSrc), 32'd1);
        step();
        chk("bne_done", 32'(state), 32'd1);

        // ORI: zero-extended OR.
        opcode = 6'b001101;
        step();
        step();
        chk("ori_state", 32'(state), 32'd9);
        chk("ori_aluop", 32'(ALUOp), 32'd4);
        chk("ori_zext", 32'(ImmZext), 32'd1);
        step();
        chk("ori_wb", 32'(state), 32'd10);
        chk("ori_wb_rw", 32'(RegWrite), 32'd1);
        step();
        chk("ori_done", 32'(state), 32'd1);

        // Opcode 111111 traps with the extended ISA too.
        opcode = 6'b111111;
        step();
        step();
        chk("ill_a_state", 32'(state), 32'd13);
        chk("ill_a_pulse", 32'(illegal_op), 32'd1);
        step();
        chk("ill_a_done", 32'(state), 32'd1);
        chk("ill_a_clr", 32'(illegal_op), 32'd0);

        // Reset mid-MEMWR: outputs drop before the next edge.
        opcode    = 6'b101011;
        mem_ready = 1'b0;
        step();
        mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        chk("mwr_state", 32'(state), 32'd6);
        chk("mwr_mw", 32'(MemWrite), 32'd1);
        step();
        chk("mwr_hold", 32'(state), 32'd6);
        reset = 1'b1;
        #1;
        chk("mwr_rst_mw", 32'(MemWrite), 32'd0);
        chk("mwr_rst_state", 32'(state), 32'd0);
        chk("mwr_rst_outs", 32'(outs_a()), 32'd0);
        step();
        reset     = 1'b0;
        mem_ready = 1'b1;
        step();
        chk("mwr_rel", 32'(state), 32'd1);
        chk("b_rel", 32'(state_b), 32'd1);

        // No-ext instance: BNE traps; FETCH never stalls on mem_ready=0.
        opcode = 6'b000101;
        #1;
        chk("b_fetch_pcw", 32'(PCWrite_b), 32'd1);
        step();
        chk("b_dec", 32'(state_b), 32'd2);
        step();
        chk("b_bne_trap", 32'(state_b), 32'd13);
        chk("b_bne_ill", 32'(illegal_op_b), 32'd1);
        chk("b_bne_outs", 32'(outs_a() == 21'd0), 32'd0);
        chk("b_trap_outs", 32'(outs_b()), 32'd1);
        step();
        chk("b_trap_done", 32'(state_b), 32'd1);
        chk("b_ill_clr", 32'(illegal_op_b), 32'd0);

        // No-ext instance: LW with mem_ready stuck low takes 5 cycles.
        opcode = 6'b100011;
        repeat (5) step();
        chk("b_lw_done", 32'(state_b), 32'd1);

        // No-ext instance: 111111 traps as well.
        opcode = 6'b111111;
        step();
        step();
        chk("b_ill_state", 32'(state_b), 32'd13);
        chk("b_ill_pulse", 32'(illegal_op_b), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle MIPS main controller, the next generation of our single-cycle `control_unit`. A Moore state machine sequences each instruction over 3–5 cycles (more with memory wait states) and drives the shared-ALU, single-memory datapath. It adds an optional memory ready handshake, an optional extended ISA (BNE, ANDI, ORI, SLTI), and illegal-opcode trapping. It sits between the instruction register's opcode field and the datapath muxes and enables.

## Interface
- `MEM_WAIT_EN`, default 1: 1 = memory states hold until `mem_ready`; 0 = `mem_ready` ignored and every memory access takes one cycle.
- `EXT_ISA`, default 1: 1 = BNE/ANDI/ORI/SLTI decoded; 0 = those opcodes trap as illegal.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: instr[31:26] from the instruction register; stable after FETCH.
- `mem_ready` in 1: memory access complete this cycle.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_req` out 1: memory access request.
- `MemWrite` out 1: memory write.
- `IRWrite` out 1: instruction register load.
- `PCWrite` out 1: unconditional PC load.
- `Branch` out 1: PC load if zero.
- `BranchNe` out 1: PC load if not zero.
- `PCSrc` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `ALUSrcA` out 1: 0 = PC, 1 = regA.
- `ALUSrcB` out 2: 00 = regB, 01 = 4, 10 = imm, 11 = imm<<2.
- `ImmZext` out 1: 1 = zero-extend imm, 0 = sign-extend.
- `ALUOp` out 3: 000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt.
- `RegDst` out 1: 1 = rd, 0 = rt.
- `MemtoReg` out 1: 1 = data register, 0 = ALUOut.
- `RegWrite` out 1: register file write.
- `illegal_op` out 1: one-cycle trap pulse.
- `state` out 4: current state, for debug.

## Operation
- **Outputs.** All outputs are Moore outputs decoded from `state`. Exception: the FETCH strobes and MEMWR exit are qualified by `mem_ready` (see below). Any output not listed for a state is 0.
- **Codes.** States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, IMMEX=9, IMMWB=10, BRANCH=11, JUMP=12, TRAP=13. Codes 14–15 go to IDLE.
- **IDLE:** all outputs 0. Next state FETCH.
- **FETCH:** IorD=0, mem_req=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSrc=00. IRWrite=PCWrite=`rdy`, where `rdy` = `mem_ready` if MEM_WAIT_EN, else 1. Go to DECODE when rdy, else stay.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). Dispatch on `opcode`:
  - 000000 → EXEC
  - 100011 (LW) or 101011 (SW) → MEMADR
  - 000100 (BEQ) → BRANCH
  - 000101 (BNE) → BRANCH, if EXT_ISA
  - 001000 (ADDI) → IMMEX
  - 001100 (ANDI), 001101 (ORI), 001010 (SLTI) → IMMEX, if EXT_ISA
  - 000010 (J) → JUMP
  - anything else → TRAP
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next MEMRD for LW, MEMWR for SW.
- **MEMRD:** IorD=1, mem_req=1. Leave to MEMWB on rdy.
- **MEMWB:** RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- **MEMWR:** IorD=1, mem_req=1, MemWrite=1, held for the whole state. Leave to FETCH on rdy.
- **EXEC:** ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next ALUWB.
- **ALUWB:** RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
- **IMMEX:** ALUSrcA=1, ALUSrcB=10. ALUOp and ImmZext by opcode:
  - ADDI: 000, ImmZext=0
  - ANDI: 011, ImmZext=1
  - ORI: 100, ImmZext=1
  - SLTI: 101, ImmZext=0
  - Next IMMWB.
- **IMMWB:** RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSrc=01. Branch=1 for BEQ, BranchNe=1 for BNE. Next FETCH.
- **JUMP:** PCSrc=10, PCWrite=1. Next FETCH.
- **TRAP:** illegal_op=1, no other writes. Next FETCH (the PC has already advanced).
- **Opcode sampling.** `opcode` is decoded in DECODE. IMMEX/MEMADR/BRANCH re-read it, which is safe because IRWrite=0 outside FETCH.

## Timing
- **Reset.** On `reset`=1, state goes asynchronously to IDLE and all outputs are 0 within the same cycle. On release, the first rising edge enters FETCH.
- **Reset mid-instruction.** The instruction is abandoned with no partial RegWrite/MemWrite after assertion.
- **Latency with zero wait states:**
  - BEQ/BNE/J/illegal: 3 cycles
  - R-type/SW/immediate: 4 cycles
  - LW: 5 cycles
- **Wait states.** Each cycle `mem_ready`=0 in FETCH/MEMRD/MEMWR adds one cycle. PCWrite/IRWrite pulse exactly once per fetch, in the rdy cycle.
- **`mem_ready` elsewhere.** Outside memory states it is ignored. `mem_ready`=1 together with reset: reset wins.
- **MEM_WAIT_EN=0.** `mem_ready` stuck at 0 must not stall.

## Test plan
- **Reset:** reset asserted mid-MEMWR with MemWrite=1 → MemWrite=0 and state=0 before the next edge. After release → FETCH on the first edge.
- **R-type:** opcode 000000, mem_ready=1 → states 1,2,7,8,1. RegWrite=1 only in state 8, with RegDst=1 and ALUOp=010 in state 7.
- **LW with waits:** opcode 100011, mem_ready low for 2 cycles in FETCH and 3 in MEMRD → 10 cycles total. PCWrite and IRWrite high for exactly 1 cycle. MemtoReg=1 with RegWrite=1 in state 5.
- **SW:** opcode 101011, ready immediately → MemWrite=1 for 1 cycle with IorD=1, and RegWrite never asserted.
- **EXT_ISA=1, BNE then ORI:** BNE gives BranchNe=1, Branch=0, ALUOp=001 in state 11. ORI gives ALUOp=100 and ImmZext=1 in state 9.
- **EXT_ISA=0:** opcode 000101 → state 13, illegal_op=1 for one cycle, then FETCH. Opcode 111111 traps under either EXT_ISA setting.
